// File: rtl/gcl_gate_ctrl.sv
// gcl_gate_ctrl: time-aware gate controller for the TSN priority scheduler.
// Walks a programmable gate control list (gate mask + duration per entry)
// while in_gcl_test_start is high. It presents the per-queue valid vector
// to the scheduler as (gate mask & queue non-empty), registered.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_gcl_wr_en/addr/gate/dur   table write port (one entry per cycle)
//   in_gcl_len            active entry count, latched on start
//   in_gcl_test_start     level: 1 = run list, 0 = idle
//   in_gcl_queue_nempty   per-queue non-empty flags
//   out_gcl_valid         gated valid vector
//   out_gcl_gate_state    current gate mask
//   out_gcl_entry_idx     active entry index
//   out_gcl_cycle_start   one-cycle pulse when entry 0 becomes active
module gcl_gate_ctrl #(
  parameter int unsigned GCL_DEPTH = 8,
  parameter int unsigned DUR_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_gcl_wr_en,
  input  logic [$clog2(GCL_DEPTH)-1:0] in_gcl_wr_addr,
  input  logic [7:0]                   in_gcl_wr_gate,
  input  logic [DUR_W-1:0]             in_gcl_wr_dur,
  input  logic [$clog2(GCL_DEPTH):0]   in_gcl_len,
  input  logic                         in_gcl_test_start,
  input  logic [7:0]                   in_gcl_queue_nempty,
  output logic [7:0]                   out_gcl_valid,
  output logic [7:0]                   out_gcl_gate_state,
  output logic [$clog2(GCL_DEPTH)-1:0] out_gcl_entry_idx,
  output logic                         out_gcl_cycle_start
);

  localparam int unsigned IDX_W     = $clog2(GCL_DEPTH);
  localparam int unsigned LEN_W     = IDX_W + 1;
  localparam logic [7:0]  GATE_OPEN = 8'hFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         gate_q, gate_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DUR_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               cs_q, cs_d;
  logic [7:0]         valid_q;

  logic [7:0]         gate_tbl [GCL_DEPTH];
  logic [DUR_W-1:0]   dur_tbl  [GCL_DEPTH];

  logic [LEN_W-1:0]   len_clamp_c;
  logic [IDX_W-1:0]   nidx_c;
  logic [DUR_W-1:0]   dur0_c;
  logic [DUR_W-1:0]   durn_c;

  // Gate control list storage; writes accepted in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < GCL_DEPTH; k++) begin
        gate_tbl[k] <= GATE_OPEN;
        dur_tbl[k]  <= DUR_W'(1);
      end
    end else if (in_gcl_wr_en) begin
      gate_tbl[in_gcl_wr_addr] <= in_gcl_wr_gate;
      dur_tbl[in_gcl_wr_addr]  <= in_gcl_wr_dur;
    end
  end

  // Length clamp to [1, GCL_DEPTH]
  always_comb begin
    len_clamp_c = in_gcl_len;
    if (in_gcl_len == '0) begin
      len_clamp_c = LEN_W'(1);
    end else if (in_gcl_len > LEN_W'(GCL_DEPTH)) begin
      len_clamp_c = LEN_W'(GCL_DEPTH);
    end
  end

  // Next entry index, wrapping at the latched length
  assign nidx_c = ((LEN_W'(idx_q) + LEN_W'(1)) == len_q) ? '0 : idx_q + IDX_W'(1);

  // Loaded durations with zero treated as one; reads see pre-write contents
  assign dur0_c = (dur_tbl[0] == '0) ? DUR_W'(1) : dur_tbl[0];
  assign durn_c = (dur_tbl[nidx_c] == '0) ? DUR_W'(1) : dur_tbl[nidx_c];

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    cs_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        gate_d = GATE_OPEN;
        idx_d  = '0;
        cnt_d  = '0;
        if (in_gcl_test_start) begin
          state_d = ST_RUN;
          len_d   = len_clamp_c;
          gate_d  = gate_tbl[0];
          cnt_d   = dur0_c;
          idx_d   = '0;
          cs_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (!in_gcl_test_start) begin
          // Stop wins over advancing
          state_d = ST_IDLE;
          gate_d  = GATE_OPEN;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == DUR_W'(1)) begin
          gate_d = gate_tbl[nidx_c];
          cnt_d  = durn_c;
          idx_d  = nidx_c;
          cs_d   = (nidx_c == '0);
        end else begin
          cnt_d = cnt_q - DUR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gate_q  <= GATE_OPEN;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_W'(1);
      cs_q    <= 1'b0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      cs_q    <= cs_d;
      valid_q <= gate_q & in_gcl_queue_nempty;
    end
  end

  assign out_gcl_valid       = valid_q;
  assign out_gcl_gate_state  = gate_q;
  assign out_gcl_entry_idx   = idx_q;
  assign out_gcl_cycle_start = cs_q;

endmodule
